eth_tx_frame_builder: RTL and testbench
=======================================

ETH_TX_FRAME_BUILDER -- requirements
Module: eth_tx_frame_builder

Interface
REQ-001 SHALL have parameter MIN_FRAME_WORDS, default 15, minimum frame length in 32-bit words before FCS (60 bytes).
REQ-002 SHALL have parameter MAX_PL_WORDS, default 374, maximum payload words accepted per frame (14+4*374+2 = 1512 bytes ≤ 1514).
REQ-003 SHALL have port clk_100_mhz  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports start in 1 (one-cycle frame request), dst_mac in 48, src_mac in 48, eth_type in 16 (all sampled on accepted start).
REQ-006 SHALL have ports pl_data in 32, pl_valid in 1, pl_last in 1, pl_ready out 1 (upstream payload stream, MSB-first bytes).
REQ-007 SHALL have ports tx_data_in out 32, tx_valid out 1, last_data out 1, tx_send out 1, tx_ready_to_write in 1, tx_ready_to_send in 1, tx_done in 1 (to transmitter).
REQ-008 SHALL have ports busy out 1, frame_done out 1 (one-cycle pulse), len_err out 1 (sticky until next accepted start).

Function
REQ-009 SHALL implement states IDLE, HDR, BODY, TAIL, PAD, SEND, WAIT_DONE.
REQ-010 IDLE: start accepted only in IDLE; latches addresses/type, clears word counter and len_err, -> HDR; start outside IDLE ignored.
REQ-011 Word transfer to transmitter SHALL occur on cycles with tx_valid && tx_ready_to_write; tx_data_in/last_data held stable while tx_valid high and not transferred.
REQ-012 HDR: emits W0=dst[47:16], W1={dst[15:0],src[47:32]}, W2=src[31:0], then -> BODY.
REQ-013 BODY: pl_ready = tx_ready_to_write (combinational); each payload beat k emits {prev_lo16, pl_data[31:16]} where prev_lo16 = eth_type for the first beat, then pl_data[15:0] of beat k-1 held in a 16-bit register.
REQ-014 tx_valid in BODY SHALL equal pl_valid; no word emitted without a payload beat.
REQ-015 On beat with pl_last -> TAIL; TAIL emits {held_lo16, 16'h0000}.
REQ-016 Word counter (9 bits) SHALL count all emitted words; if count after TAIL < MIN_FRAME_WORDS -> PAD emitting 32'h0 words until count = MIN_FRAME_WORDS, else -> SEND.
REQ-017 last_data SHALL be high only with the final emitted word (TAIL word if no padding, else last PAD word).
REQ-018 Payload beats beyond MAX_PL_WORDS SHALL be accepted (pl_ready high) and discarded, len_err set; frame terminates normally at pl_last with the truncated content.
REQ-019 SEND: wait tx_ready_to_send, drive tx_send high exactly one cycle, -> WAIT_DONE.
REQ-020 WAIT_DONE: on tx_done pulse frame_done one cycle, -> IDLE; start in that same cycle ignored.
REQ-021 busy SHALL be high in every state except IDLE; pl_ready low outside BODY.
REQ-022 Latency: first tx_valid SHALL rise the cycle after start accepted.

Reset
REQ-023 Asserting rst SHALL force state IDLE and all outputs low (tx_data_in 0, counter 0, len_err 0), including mid-frame; no partial tx_send issued afterwards.
REQ-024 After rst deassertion block SHALL accept start on the first rising edge.

Structure
REQ-025 Shared package eth_pkg SHALL hold the state enum, MIN_FRAME_WORDS/MAX_PL_WORDS defaults and header word-index constants.
REQ-026 No sub-module; halfword realignment register and counter inline.

Verification
REQ-027 dst=FF..FF, src=00_0A_35_01_02_03, type=0800, 12 payload words 0x11111111..0xCCCCCCCC -> 16 words, W3=0800_1111, W15=CCCC_0000 with last_data, one tx_send, one frame_done.
REQ-028 1 payload word 0xDEADBEEF -> W3=0800_DEAD, W4=BEEF_0000, W5..W14 zero, last_data on W14 (15 words total).
REQ-029 tx_ready_to_write toggled every other cycle during 20-word payload -> pl_ready mirrors it, no dropped/duplicated words, data stable while stalled.
REQ-030 400 payload words -> 374 forwarded, 26 discarded, len_err=1, frame ends with TAIL word, frame_done pulsed.
REQ-031 rst asserted during BODY word 5 -> all outputs 0 next edge; fresh start afterward produces correct frame from W0.
REQ-032 start pulsed during WAIT_DONE and on tx_done cycle -> ignored, busy/frame_done sequence unchanged.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX frame builder: FSM states, default
// frame-size limits and header word indices.
package eth_pkg;

  localparam int CNT_W               = 9;
  localparam int MIN_FRAME_WORDS_DEF = 15;
  localparam int MAX_PL_WORDS_DEF    = 374;

  localparam logic [CNT_W-1:0] HDR_W0 = 9'd0;
  localparam logic [CNT_W-1:0] HDR_W1 = 9'd1;
  localparam logic [CNT_W-1:0] HDR_W2 = 9'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_TAIL,
    S_PAD,
    S_SEND,
    S_WAIT_DONE
  } state_e;

endpackage

// File: rtl/eth_tx_frame_builder.sv
// Builds an Ethernet frame as 32-bit words: MAC header, payload realigned by a
// halfword behind the 16-bit type field, zero padding, then a send handshake.
module eth_tx_frame_builder
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_WORDS = MIN_FRAME_WORDS_DEF,
  parameter int MAX_PL_WORDS    = MAX_PL_WORDS_DEF
) (
  input  logic        clk_100_mhz,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic [31:0] tx_data_in,
  output logic        tx_valid,
  output logic        last_data,
  output logic        tx_send,
  input  logic        tx_ready_to_write,
  input  logic        tx_ready_to_send,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err
);

  localparam logic [CNT_W-1:0] MIN_WORDS = CNT_W'(MIN_FRAME_WORDS);
  localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(MAX_PL_WORDS);

  state_e           state_q, state_d;
  logic [47:0]      dst_q, dst_d;
  logic [47:0]      src_q, src_d;
  logic [15:0]      held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             len_err_q, len_err_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             discard;

  assign cnt_inc = cnt_q + 1'b1;
  // Once the payload budget is spent, further beats are drained without output.
  assign discard = (beats_q >= MAX_BEATS);
  assign busy    = (state_q != S_IDLE);
  assign len_err = len_err_q;

  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dst_q     <= '0;
      src_q     <= '0;
      held_q    <= '0;
      cnt_q     <= '0;
      beats_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path infers a latch.
    state_d    = state_q;
    dst_d      = dst_q;
    src_d      = src_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    beats_d    = beats_q;
    len_err_d  = len_err_q;
    tx_data_in = '0;
    tx_valid   = 1'b0;
    last_data  = 1'b0;
    tx_send    = 1'b0;
    pl_ready   = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dst_d     = dst_mac;
          src_d     = src_mac;
          // The type field occupies the upper half of the first payload word.
          held_d    = eth_type;
          cnt_d     = '0;
          beats_d   = '0;
          len_err_d = 1'b0;
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        tx_valid = 1'b1;
        case (cnt_q)
          HDR_W0:  tx_data_in = dst_q[47:16];
          HDR_W1:  tx_data_in = {dst_q[15:0], src_q[47:32]};
          default: tx_data_in = src_q[31:0];
        endcase
        if (tx_ready_to_write) begin
          cnt_d = cnt_inc;
          if (cnt_q == HDR_W2) state_d = S_BODY;
        end
      end

      S_BODY: begin
        pl_ready = tx_ready_to_write;
        if (!discard) begin
          tx_valid   = pl_valid;
          tx_data_in = {held_q, pl_data[31:16]};
        end
        if (pl_valid && tx_ready_to_write) begin
          if (discard) begin
            len_err_d = 1'b1;
          end else begin
            held_d  = pl_data[15:0];
            cnt_d   = cnt_inc;
            beats_d = beats_q + 1'b1;
          end
          if (pl_last) state_d = S_TAIL;
        end
      end

      S_TAIL: begin
        tx_valid   = 1'b1;
        tx_data_in = {held_q, 16'h0000};
        last_data  = (cnt_inc >= MIN_WORDS);
        if (tx_ready_to_write) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc >= MIN_WORDS) ? S_SEND : S_PAD;
        end
      end

      S_PAD: begin
        tx_valid  = 1'b1;
        last_data = (cnt_inc >= MIN_WORDS);
        if (tx_ready_to_write) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= MIN_WORDS) state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (tx_ready_to_send) begin
          tx_send = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (tx_done) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
// Self-checking bench for eth_tx_frame_builder: table-driven frame scenarios,
// a mid-frame reset sequence and random frames against a byte-level frame model.
module tb_eth_tx_frame_builder;
  import eth_pkg::*;

  logic        clk_100_mhz = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] eth_type = '0;
  logic [31:0] pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_last = 1'b0;
  logic        pl_ready;
  logic [31:0] tx_data_in;
  logic        tx_valid;
  logic        last_data;
  logic        tx_send;
  logic        tx_ready_to_write = 1'b0;
  logic        tx_ready_to_send = 1'b0;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        len_err;

  always #5 clk_100_mhz = ~clk_100_mhz;

  eth_tx_frame_builder dut (
    .clk_100_mhz       (clk_100_mhz),
    .rst               (rst),
    .start             (start),
    .dst_mac           (dst_mac),
    .src_mac           (src_mac),
    .eth_type          (eth_type),
    .pl_data           (pl_data),
    .pl_valid          (pl_valid),
    .pl_last           (pl_last),
    .pl_ready          (pl_ready),
    .tx_data_in        (tx_data_in),
    .tx_valid          (tx_valid),
    .last_data         (last_data),
    .tx_send           (tx_send),
    .tx_ready_to_write (tx_ready_to_write),
    .tx_ready_to_send  (tx_ready_to_send),
    .tx_done           (tx_done),
    .busy              (busy),
    .frame_done        (frame_done),
    .len_err           (len_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pay_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          n_send = 0;
  int          n_done = 0;
  logic        stalled = 1'b0;
  logic [32:0] stall_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer monitor: collects accepted words and checks hold-while-stalled.
  always @(negedge clk_100_mhz) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {30'h0, tx_valid, last_data, tx_data_in}, {30'h0, 1'b1, stall_word});
      if (tx_valid && tx_ready_to_write) got_q.push_back({last_data, tx_data_in});
      stalled    = tx_valid && !tx_ready_to_write;
      stall_word = {last_data, tx_data_in};
      if (tx_send)    n_send++;
      if (frame_done) n_done++;
    end
  end

  // Reference model: lay the frame out as bytes, then cut it into words.
  function automatic void build_exp(input logic [47:0] d, input logic [47:0] s,
                                    input logic [15:0] t, input int n);
    byte unsigned b[$];
    int kept;
    int nw;
    exp_q.delete();
    for (int i = 5; i >= 0; i--) b.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(s[8*i +: 8]);
    b.push_back(t[15:8]);
    b.push_back(t[7:0]);
    kept = (n > MAX_PL_WORDS_DEF) ? MAX_PL_WORDS_DEF : n;
    for (int k = 0; k < kept; k++)
      for (int j = 3; j >= 0; j--) b.push_back(pay_q[k][8*j +: 8]);
    b.push_back(8'h00);
    b.push_back(8'h00);
    while (b.size() < 4 * MIN_FRAME_WORDS_DEF) b.push_back(8'h00);
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++)
      exp_q.push_back({(w == nw - 1), b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
  endfunction

  function automatic logic [32:0] got_at(input int i);
    if (i >= 0 && i < got_q.size()) return got_q[i];
    return 33'h1_dead_dead;
  endfunction

  // mode 0: always ready; 1: tx_ready_to_write toggles; 2: random ready/valid.
  task automatic run_frame(input string tag, input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input int mode, input bit start_in_wait);
    int n = pay_q.size();
    int idx = 0;
    int cyc = 0;
    int done_cnt = -1;
    bit hold = 1'b0;
    bit fin = 1'b0;
    bit sent = 1'b0;
    got_q.delete();
    n_send = 0;
    n_done = 0;
    build_exp(d, s, t, n);
    dst_mac = d; src_mac = s; eth_type = t;
    pl_valid = 1'b0; pl_last = 1'b0; tx_done = 1'b0;
    tx_ready_to_write = 1'b0; tx_ready_to_send = 1'b0;
    start = 1'b1;
    @(posedge clk_100_mhz); #1;
    start = 1'b0;
    check({tag, "_first_valid_busy"}, {tx_valid, busy}, 2'b11);
    while (!fin && cyc < 3000) begin
      case (mode)
        0:       tx_ready_to_write = 1'b1;
        1:       tx_ready_to_write = (cyc % 2 == 0);
        default: tx_ready_to_write = ($urandom_range(0, 3) != 0);
      endcase
      if (!hold) pl_valid = (idx < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      pl_data = (idx < n) ? pay_q[idx] : $urandom;
      pl_last = (idx == n - 1);
      tx_ready_to_send = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_done = (done_cnt == 0);
      if (start_in_wait) start = sent;
      @(negedge clk_100_mhz);
      if (pl_ready) check({tag, "_pl_ready_mirror"}, tx_ready_to_write, 1);
      hold = pl_valid && !pl_ready;
      if (pl_valid && pl_ready) idx++;
      if (tx_send) begin
        sent = 1'b1;
        done_cnt = 3;
      end else if (done_cnt >= 0) begin
        done_cnt--;
      end
      if (frame_done) fin = 1'b1;
      cyc++;
      @(posedge clk_100_mhz); #1;
    end
    start = 1'b0; pl_valid = 1'b0; pl_last = 1'b0; tx_done = 1'b0;
    tx_ready_to_write = 1'b1;
    check({tag, "_completed"}, fin, 1);
    repeat (3) @(posedge clk_100_mhz);
    #1;
    check({tag, "_idle_after"}, {busy, tx_valid}, 2'b00);
    check({tag, "_word_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_at(i), exp_q[i]);
    check({tag, "_tx_send_pulses"}, n_send, 1);
    check({tag, "_frame_done_pulses"}, n_done, 1);
    check({tag, "_len_err"}, len_err, (n > MAX_PL_WORDS_DEF));
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    int          n;
    int          kind;
    int          mode;
    bit          wait_start;
    int          exp_words;
    bit          exp_len_err;
    logic [31:0] exp_w3;
    logic [31:0] exp_wlast;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    int sends_before;
    int n_rand;

    // kind 0: 0x11111111*(k+1); 1: 0xDEADBEEF; 2: random
    vecs[0] = '{48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0800, 12,  0, 0, 1'b0, 16,  1'b0, 32'h0800_1111, 32'hCCCC_0000};
    vecs[1] = '{48'h1234_5678_9ABC, 48'h000A_3501_0203, 16'h0800, 1,   1, 0, 1'b1, 15,  1'b0, 32'h0800_DEAD, 32'h0000_0000};
    vecs[2] = '{48'h0200_5E10_2030, 48'h0011_2233_4455, 16'h86DD, 20,  2, 1, 1'b0, 24,  1'b0, 32'h0, 32'h0};
    vecs[3] = '{48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0806, 400, 2, 0, 1'b0, 378, 1'b1, 32'h0, 32'h0};
    vecs[4] = '{48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h0800, 11,  2, 0, 1'b0, 15,  1'b0, 32'h0, 32'h0};
    vecs[5] = '{48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h0800, 10,  2, 0, 1'b0, 15,  1'b0, 32'h0, 32'h0};
    vecs[6] = '{48'h5555_AAAA_5555, 48'hAAAA_5555_AAAA, 16'h88B5, 374, 2, 0, 1'b0, 378, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{48'h5555_AAAA_5555, 48'hAAAA_5555_AAAA, 16'h88B5, 375, 2, 0, 1'b0, 378, 1'b1, 32'h0, 32'h0};

    repeat (3) @(posedge clk_100_mhz);
    #1;
    check("reset_ctrl_outputs", {tx_valid, last_data, tx_send, busy, frame_done, len_err, pl_ready}, 7'b0);
    check("reset_tx_data", tx_data_in, 32'h0);

    // Deassert with start already presented so the first edge accepts it.
    @(negedge clk_100_mhz);
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      pay_q.delete();
      for (int k = 0; k < vecs[v].n; k++)
        case (vecs[v].kind)
          0:       pay_q.push_back(32'h1111_1111 * 32'(k + 1));
          1:       pay_q.push_back(32'hDEAD_BEEF);
          default: pay_q.push_back($urandom);
        endcase
      run_frame($sformatf("vec%0d", v), vecs[v].dst, vecs[v].src, vecs[v].etype,
                vecs[v].mode, vecs[v].wait_start);
      check($sformatf("vec%0d_exp_words", v), got_q.size(), vecs[v].exp_words);
      check($sformatf("vec%0d_exp_len_err", v), len_err, vecs[v].exp_len_err);
      if (vecs[v].kind != 2) begin
        check($sformatf("vec%0d_w3", v), got_at(3), {1'b0, vecs[v].exp_w3});
        check($sformatf("vec%0d_wlast", v), got_at(vecs[v].exp_words - 1), {1'b1, vecs[v].exp_wlast});
      end
    end

    // Reset while the fifth payload word is on the bus.
    pay_q.delete();
    for (int k = 0; k < 12; k++) pay_q.push_back($urandom);
    got_q.delete();
    @(negedge clk_100_mhz);
    dst_mac = 48'hDDDD_0000_1111; src_mac = 48'h5555_2222_3333; eth_type = 16'h0800;
    tx_ready_to_write = 1'b1; start = 1'b1;
    @(posedge clk_100_mhz); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    do begin
      pl_valid = 1'b1;
      pl_data  = pay_q[idx];
      pl_last  = 1'b0;
      @(negedge clk_100_mhz);
      if (pl_ready) idx++;
      cyc++;
      if (idx < 5) begin
        @(posedge clk_100_mhz); #1;
      end
    end while (idx < 5 && cyc < 50);
    check("rst_reached_body_word5", idx, 5);
    sends_before = n_send;
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", {tx_valid, last_data, tx_send, busy, frame_done, len_err, pl_ready}, 7'b0);
    check("rst_async_data", tx_data_in, 32'h0);
    @(posedge clk_100_mhz); #1;
    check("rst_edge_ctrl", {tx_valid, tx_send, busy, pl_ready}, 4'b0);
    repeat (2) @(posedge clk_100_mhz);
    @(negedge clk_100_mhz);
    check("rst_no_send", n_send, sends_before);
    rst = 1'b0;
    pl_valid = 1'b0;
    run_frame("post_rst", 48'hDDDD_0000_1111, 48'h5555_2222_3333, 16'h0800, 0, 1'b0);

    // Random frames against the model.
    for (int r = 0; r < 6; r++) begin
      n_rand = $urandom_range(1, 40);
      pay_q.delete();
      for (int k = 0; k < n_rand; k++) pay_q.push_back($urandom);
      run_frame($sformatf("rand%0d", r), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)},
                16'($urandom), 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
